// File: rtl/maze_path_rle_pkg.sv
// maze_path_rle_pkg: shared definitions for the maze path run-length encoder.
// Contents: the direction codes, the maze interior bounds and goal cell, the
// FSM state encoding, the segment record, and a bounds-check helper.
`timescale 1ns/1ps
package maze_path_rle_pkg;

  // Step directions as produced by the maze solver
  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  // Walker coordinates are 5-bit; the legal interior is 1..17 on both axes
  localparam int              COORD_W   = 5;
  localparam logic [COORD_W-1:0] COORD_MIN = 5'd1;
  localparam logic [COORD_W-1:0] COORD_MAX = 5'd17;
  localparam logic [COORD_W-1:0] GOAL_X    = 5'd17;
  localparam logic [COORD_W-1:0] GOAL_Y    = 5'd17;

  localparam int LEN_W  = 5;  // run length field
  localparam int STEP_W = 9;  // path step counter, saturating
  localparam int SEG_W  = 2 + LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  typedef struct packed {
    logic [1:0]       dir;
    logic [LEN_W-1:0] len;
    logic             last;
  } seg_t;

  function automatic logic in_bounds(input logic [COORD_W-1:0] c);
    return (c >= COORD_MIN) && (c <= COORD_MAX);
  endfunction

endpackage

// File: rtl/maze_seg_fifo.sv
// maze_seg_fifo: synchronous first-word-fall-through FIFO for encoded segments.
// The head entry sits in an output register so the consumer sees registered
// data. A write while full with no simultaneous read is dropped and flagged.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        request to enqueue wr_data
//   wr_data      entry to enqueue
//   rd_en        consumer accepts the head (ignored when empty)
//   rd_data      registered head entry
//   valid        head entry present (FIFO not empty)
//   full         all DEPTH entries occupied
//   drop         this cycle's write is lost because the FIFO is full
`timescale 1ns/1ps
module maze_seg_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] head_q, head_next;
  logic             valid_q;
  logic             empty, push, pop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign pop        = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign push       = wr_en && (!full || pop);
  assign drop       = wr_en && full && !pop;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign count_next = count + CW'(push) - CW'(pop);

  // Next value of the head register: the entry behind the popped one, or the
  // incoming write when it lands in an otherwise empty FIFO.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    head_next = head_q;
    if (pop) begin
      if (count > CW'(1)) begin
        head_next = mem[rd_ptr_inc];
      end else if (push) begin
        head_next = wr_data;
      end
    end else if (empty && push) begin
      head_next = wr_data;
    end
  end

  // NOTE: storage array has no reset; validity is tracked by count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      count   <= count_next;
      head_q  <= head_next;
      valid_q <= (count_next != '0);
    end
  end

  assign rd_data = head_q;
  assign valid   = valid_q;

endmodule

// File: rtl/maze_path_rle.sv
// maze_path_rle: run-length encoder and path checker behind the maze solver.
// Each burst of in_valid cycles is one path; contiguous equal directions are
// packed into (dir, len) segments of at most MAXRUN and queued in a FIFO.
// The walker position is tracked from (1,1) to flag out-of-maze steps and a
// path that does not finish on the goal cell.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      solver step valid (one high burst = one path)
//   in            step direction: 00 right, 01 down, 10 left, 11 up
//   out_ready     consumer accepts the head segment
//   out_valid     head segment valid
//   out_dir       head segment direction
//   out_len       head segment length 1..MAXRUN
//   out_last      head segment closes its path
//   done          one-cycle pulse once a path's last segment is enqueued
//   steps         step count of the most recent path (saturates at 511)
//   err_bound     sticky: a step left the 1..17 interior
//   err_end       sticky: path finished off the goal cell
//   err_ovf       sticky: a segment was dropped on a full FIFO
`timescale 1ns/1ps
module maze_path_rle
  import maze_path_rle_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int MAXRUN = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        out_dir,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_last,
  output logic              done,
  output logic [STEP_W-1:0] steps,
  output logic              err_bound,
  output logic              err_end,
  output logic              err_ovf
);

  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAXRUN);
  localparam logic [STEP_W-1:0] STEP_SAT = '1;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, y_q, base_x, base_y, next_x, next_y;
  logic [1:0]          run_dir_q;
  logic [LEN_W-1:0]    run_len_q;
  logic [STEP_W-1:0]   step_cnt_q, steps_q;
  logic                done_q, err_bound_q, err_end_q, err_ovf_q;
  logic                start, extend, step_oob, close_path;
  logic                enq_valid;
  seg_t                enq_seg, head_seg;
  logic                fifo_full, fifo_drop;

  // A step outside RUN opens a new path, so it is applied from (1,1)
  assign start      = in_valid && (state_q != ST_RUN);
  assign close_path = (state_q == ST_RUN) && !in_valid;
  assign extend     = (state_q == ST_RUN) && in_valid &&
                      (in == run_dir_q) && (run_len_q != MAX_LEN);
  assign base_x     = start ? COORD_MIN : x_q;
  assign base_y     = start ? COORD_MIN : y_q;

  // Position arithmetic wraps at 5 bits; leaving 1..17 is flagged, not clamped
  always_comb begin
    next_x = base_x;
    next_y = base_y;
    unique case (in)
      DIR_RIGHT: next_x = base_x + 1'b1;
      DIR_DOWN:  next_y = base_y + 1'b1;
      DIR_LEFT:  next_x = base_x - 1'b1;
      DIR_UP:    next_y = base_y - 1'b1;
      default:   ;
    endcase
  end

  assign step_oob = !in_bounds(next_x) || !in_bounds(next_y);

  always_comb begin
    state_d   = state_q;
    enq_valid = 1'b0;
    enq_seg   = '{dir: run_dir_q, len: run_len_q, last: 1'b0};
    unique case (state_q)
      ST_IDLE, ST_FLUSH: begin
        state_d = in_valid ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!in_valid) begin
          enq_valid    = 1'b1;
          enq_seg.last = 1'b1;
          state_d      = ST_FLUSH;
        end else if (!extend) begin
          enq_valid = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= COORD_MIN;
      y_q         <= COORD_MIN;
      run_dir_q   <= '0;
      run_len_q   <= '0;
      step_cnt_q  <= '0;
      steps_q     <= '0;
      done_q      <= 1'b0;
      err_bound_q <= 1'b0;
      err_end_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= close_path;

      if (in_valid) begin
        x_q <= next_x;
        y_q <= next_y;
      end

      if (start) begin
        run_dir_q   <= in;
        run_len_q   <= LEN_W'(1);
        step_cnt_q  <= STEP_W'(1);
        err_bound_q <= step_oob;
        err_end_q   <= 1'b0;
        err_ovf_q   <= 1'b0;
      end else begin
        if (in_valid) begin
          if (extend) begin
            run_len_q <= run_len_q + 1'b1;
          end else begin
            run_dir_q <= in;
            run_len_q <= LEN_W'(1);
          end
          if (step_cnt_q != STEP_SAT) step_cnt_q <= step_cnt_q + 1'b1;
          if (step_oob) err_bound_q <= 1'b1;
        end
        if (fifo_drop) err_ovf_q <= 1'b1;
        if (close_path) begin
          steps_q <= step_cnt_q;
          if ((x_q != GOAL_X) || (y_q != GOAL_Y)) err_end_q <= 1'b1;
        end
      end
    end
  end

  maze_seg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SEG_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (enq_valid),
    .wr_data (enq_seg),
    .rd_en   (out_ready),
    .rd_data (head_seg),
    .valid   (out_valid),
    .full    (fifo_full),
    .drop    (fifo_drop)
  );

  assign out_dir   = head_seg.dir;
  assign out_len   = head_seg.len;
  assign out_last  = head_seg.last;
  assign done      = done_q;
  assign steps     = steps_q;
  assign err_bound = err_bound_q;
  assign err_end   = err_end_q;
  assign err_ovf   = err_ovf_q;

endmodule
